// File: rtl/memory_arbiter.sv
// Two-requester arbiter for a single-port word memory: p0 = instruction fetch, p1 = load/store.
// Each access takes IDLE -> ACCESS -> ACK. Memory controls and the requester responses are registered.
module memory_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int MEM_WORDS   = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic [29:0] p0_address,
  input  logic        p0_write,
  input  logic [31:0] p0_data_in,
  input  logic [3:0]  p0_strobes,
  output logic [31:0] p0_data_out,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [29:0] p1_address,
  input  logic        p1_write,
  input  logic [31:0] p1_data_in,
  input  logic [3:0]  p1_strobes,
  output logic [31:0] p1_data_out,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [3:0]  mem_strobes,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester raises req with its fields and holds them until its
  // one-cycle ack. Fields are latched at grant, and no grant is made from ACK.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state, state_nxt;
  logic        last_grant;   // 1 = p1 was granted most recently
  logic        winner;       // 1 = p1 owns the access in flight
  logic        err_pending;
  logic        was_write;
  logic        grant_any;
  logic        grant_p1;
  logic [29:0] sel_address;
  logic [31:0] sel_data;
  logic [3:0]  sel_strobes;
  logic        sel_write;
  logic        sel_oor;

  assign state_dbg = state;

  always_comb begin
    grant_any   = p0_req | p1_req;
    // With round robin, p1 loses a contended grant only if it won the last one.
    grant_p1    = p1_req & (~p0_req | ~last_grant | (ROUND_ROBIN == 0));
    sel_address = grant_p1 ? p1_address : p0_address;
    sel_data    = grant_p1 ? p1_data_in : p0_data_in;
    sel_strobes = grant_p1 ? p1_strobes : p0_strobes;
    sel_write   = grant_p1 ? p1_write   : p0_write;
    // Full 30-bit compare so high address bits never alias into the array.
    sel_oor     = ({2'b00, sel_address} >= MEM_LIMIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= 1'b1;
      winner      <= 1'b0;
      err_pending <= 1'b0;
      was_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_strobes <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      p0_data_out <= '0;
      p0_ack      <= 1'b0;
      p0_err      <= 1'b0;
      p1_data_out <= '0;
      p1_ack      <= 1'b0;
      p1_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            winner      <= grant_p1;
            mem_address <= sel_address;
            mem_data_in <= sel_data;
            mem_strobes <= sel_strobes;
            was_write   <= sel_write;
            err_pending <= sel_oor;
            mem_read    <= ~sel_write & ~sel_oor;
            mem_write   <= sel_write & ~sel_oor;
          end
        end
        ACCESS: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          last_grant <= winner;
          if (winner) begin
            p1_ack <= 1'b1;
            p1_err <= err_pending;
            if (!was_write) p1_data_out <= err_pending ? 32'd0 : mem_data_out;
          end else begin
            p0_ack <= 1'b1;
            p0_err <= err_pending;
            if (!was_write) p0_data_out <= err_pending ? 32'd0 : mem_data_out;
          end
        end
        ACK: begin
          p0_ack <= 1'b0;
          p0_err <= 1'b0;
          p1_ack <= 1'b0;
          p1_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
